// File: rtl/iserdese3_4to10_gearbox_if.sv
// Bus between the ISERDESE3 nibble source and the 4:10 gearbox.
// The master drives deserialised nibbles and manual slip requests.
// The slave returns aligned 10-bit TMDS symbols and lock status.
interface iserdese3_4to10_gearbox_if;
    logic [3:0] rxdata;      // ISERDESE3 Q[3:0], bit 0 earliest
    logic       bitslip;     // one-cycle manual slip request
    logic [9:0] rxword;      // aligned symbol, bit 0 earliest
    logic       rxword_vld;  // one-cycle strobe for rxword
    logic       aligned;     // locked on control tokens
    logic [3:0] slip_cnt;    // slips applied, modulo 10

    modport master (
        output rxdata,
        output bitslip,
        input  rxword,
        input  rxword_vld,
        input  aligned,
        input  slip_cnt
    );

    modport slave (
        input  rxdata,
        input  bitslip,
        output rxword,
        output rxword_vld,
        output aligned,
        output slip_cnt
    );
endinterface

// File: rtl/iserdese3_4to10_gearbox.sv
// Receive-side 4:10 gearbox for the TMDS input path.
// Packs 4-bit ISERDESE3 nibbles LSB-first into 10-bit symbols (2 symbols
// per 5 clkdiv4 cycles) and, optionally, hunts for word alignment by
// bit-slipping until TMDS control tokens repeat.
module iserdese3_4to10_gearbox #(
    parameter bit AUTO_ALIGN   = 1'b1,
    parameter int LOCK_CNT     = 16,
    parameter int SEARCH_WORDS = 64,
    parameter int LOSS_WORDS   = 4096
) (
    input  logic                             clkdiv4,
    input  logic                             rxrst_n,
    iserdese3_4to10_gearbox_if.slave         gb
);

    // Counter sizing: word counter serves both the search and the loss window.
    localparam int WORD_MAX = (SEARCH_WORDS > LOSS_WORDS) ? SEARCH_WORDS : LOSS_WORDS;
    localparam int MW       = $clog2(LOCK_CNT + 1);
    localparam int WW       = $clog2(WORD_MAX + 1);

    localparam logic [MW-1:0] MATCH_LAST  = MW'(LOCK_CNT - 1);
    localparam logic [WW-1:0] SEARCH_LAST = WW'(SEARCH_WORDS - 1);
    localparam logic [WW-1:0] LOSS_LAST   = WW'(LOSS_WORDS - 1);

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_SLIP   = 2'd1,
        ST_WAIT   = 2'd2,
        ST_LOCKED = 2'd3
    } state_t;

    // The four TMDS control-period symbols (C1C0 = 00, 01, 10, 11).
    function automatic logic is_token(input logic [9:0] w);
        return (w == 10'h354) || (w == 10'h0AB) || (w == 10'h154) || (w == 10'h2AB);
    endfunction

    // Datapath state
    logic [13:0] sbuf_q, sbuf_d, sbuf_s;
    logic [3:0]  fill_q, fill_d, fill_s;
    logic [9:0]  rxword_q, rxword_d;
    logic        rxword_vld_q, rxword_vld_d;
    logic [3:0]  slip_cnt_q, slip_cnt_d;
    logic        emit_s;
    logic        slip_s;

    // Aligner state
    state_t       state_q;
    logic [MW-1:0] match_cnt_q;
    logic [WW-1:0] word_cnt_q;
    logic [1:0]    wait_cnt_q;
    logic          aligned_q;

    // Aligner decisions on the word currently presented at the output
    logic token_s;
    logic lock_hit_s;
    logic search_hit_s;
    logic loss_hit_s;
    logic wait_done_s;

    // Select the slip source: the aligner in auto mode, the port otherwise.
    always_comb begin
        slip_s = 1'b0;
        if (AUTO_ALIGN) begin
            slip_s = (state_q == ST_SLIP);
        end else begin
            slip_s = gb.bitslip;
        end
    end

    // Append the new nibble, discarding the oldest bit first on a slip.
    always_comb begin
        sbuf_s = sbuf_q;
        fill_s = fill_q;
        if (slip_s && (fill_q == 4'd0)) begin
            // Nothing buffered: the oldest bit is rxdata[0] itself.
            sbuf_s = {11'd0, gb.rxdata[3:1]};
            fill_s = 4'd3;
        end else if (slip_s) begin
            sbuf_s = sbuf_q >> 1;
            fill_s = fill_q - 4'd1;
            sbuf_s[fill_s +: 4] = gb.rxdata;
            fill_s = fill_s + 4'd4;
        end else begin
            sbuf_s[fill_q +: 4] = gb.rxdata;
            fill_s = fill_q + 4'd4;
        end
    end

    // Pop a completed symbol once ten or more bits are buffered.
    always_comb begin
        emit_s       = 1'b0;
        sbuf_d       = sbuf_s;
        fill_d       = fill_s;
        rxword_d     = rxword_q;
        rxword_vld_d = 1'b0;
        if (fill_s >= 4'd10) begin
            emit_s       = 1'b1;
            rxword_d     = sbuf_s[9:0];
            rxword_vld_d = 1'b1;
            sbuf_d       = sbuf_s >> 10;
            fill_d       = fill_s - 4'd10;
        end else begin
            emit_s       = 1'b0;
        end
    end

    // Track the bit phase modulo one symbol.
    always_comb begin
        slip_cnt_d = slip_cnt_q;
        if (slip_s) begin
            slip_cnt_d = (slip_cnt_q == 4'd9) ? 4'd0 : (slip_cnt_q + 4'd1);
        end else begin
            slip_cnt_d = slip_cnt_q;
        end
    end

    // Gearbox buffer, output symbol and phase counter registers.
    always_ff @(posedge clkdiv4 or negedge rxrst_n) begin
        if (!rxrst_n) begin
            sbuf_q       <= 14'd0;
            fill_q       <= 4'd0;
            rxword_q     <= 10'd0;
            rxword_vld_q <= 1'b0;
            slip_cnt_q   <= 4'd0;
        end else begin
            sbuf_q       <= sbuf_d;
            fill_q       <= fill_d;
            rxword_q     <= rxword_d;
            rxword_vld_q <= rxword_vld_d;
            slip_cnt_q   <= slip_cnt_d;
        end
    end

    // Threshold decisions for the aligner, evaluated on each valid word.
    always_comb begin
        token_s      = 1'b0;
        lock_hit_s   = 1'b0;
        search_hit_s = 1'b0;
        loss_hit_s   = 1'b0;
        wait_done_s  = 1'b0;
        if (rxword_vld_q) begin
            token_s      = is_token(rxword_q);
            lock_hit_s   = is_token(rxword_q) && (match_cnt_q == MATCH_LAST);
            search_hit_s = (word_cnt_q == SEARCH_LAST);
            loss_hit_s   = !is_token(rxword_q) && (word_cnt_q == LOSS_LAST);
            wait_done_s  = (wait_cnt_q == 2'd3);
        end else begin
            token_s      = 1'b0;
        end
    end

    // Alignment FSM: search for repeating tokens, slip, settle, hold lock.
    always_ff @(posedge clkdiv4 or negedge rxrst_n) begin
        if (!rxrst_n) begin
            state_q     <= ST_SEARCH;
            match_cnt_q <= '0;
            word_cnt_q  <= '0;
            wait_cnt_q  <= 2'd0;
            aligned_q   <= 1'b0;
        end else if (!AUTO_ALIGN) begin
            state_q     <= ST_SEARCH;
            match_cnt_q <= '0;
            word_cnt_q  <= '0;
            wait_cnt_q  <= 2'd0;
            aligned_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_SEARCH: begin
                    if (!rxword_vld_q) begin
                        state_q <= ST_SEARCH;
                    end else if (lock_hit_s) begin
                        // Lock takes priority over a coincident search timeout.
                        state_q     <= ST_LOCKED;
                        aligned_q   <= 1'b1;
                        match_cnt_q <= '0;
                        word_cnt_q  <= '0;
                    end else if (search_hit_s) begin
                        state_q     <= ST_SLIP;
                        match_cnt_q <= '0;
                        word_cnt_q  <= '0;
                    end else begin
                        match_cnt_q <= token_s ? (match_cnt_q + 1'b1) : '0;
                        word_cnt_q  <= word_cnt_q + 1'b1;
                    end
                end
                ST_SLIP: begin
                    // The slip itself is taken by the datapath during this state.
                    state_q    <= ST_WAIT;
                    wait_cnt_q <= 2'd0;
                end
                ST_WAIT: begin
                    // Words straddling the old phase are ignored.
                    if (!rxword_vld_q) begin
                        state_q <= ST_WAIT;
                    end else if (wait_done_s) begin
                        state_q     <= ST_SEARCH;
                        wait_cnt_q  <= 2'd0;
                        match_cnt_q <= '0;
                        word_cnt_q  <= '0;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 2'd1;
                    end
                end
                ST_LOCKED: begin
                    if (!rxword_vld_q) begin
                        state_q <= ST_LOCKED;
                    end else if (token_s) begin
                        word_cnt_q <= '0;
                    end else if (loss_hit_s) begin
                        // Lost lock: resume searching from the current phase.
                        state_q     <= ST_SEARCH;
                        aligned_q   <= 1'b0;
                        match_cnt_q <= '0;
                        word_cnt_q  <= '0;
                    end else begin
                        word_cnt_q <= word_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_SEARCH;
                    aligned_q   <= 1'b0;
                    match_cnt_q <= '0;
                    word_cnt_q  <= '0;
                    wait_cnt_q  <= 2'd0;
                end
            endcase
        end
    end

    assign gb.rxword     = rxword_q;
    assign gb.rxword_vld = rxword_vld_q;
    assign gb.aligned    = aligned_q;
    assign gb.slip_cnt   = slip_cnt_q;

endmodule

// File: tb/tb_iserdese3_4to10_gearbox.sv
// Directed bench for the 4:10 gearbox: one auto-aligning instance and one
// manual-slip instance fed from the same serial bit stream.
module tb_iserdese3_4to10_gearbox;

    logic clk = 1'b0;
    logic rxrst_n;
    always #5 clk = ~clk;

    iserdese3_4to10_gearbox_if ifa ();
    iserdese3_4to10_gearbox_if ifm ();

    iserdese3_4to10_gearbox dut_a (
        .clkdiv4 (clk),
        .rxrst_n (rxrst_n),
        .gb      (ifa.slave)
    );

    iserdese3_4to10_gearbox #(.AUTO_ALIGN(1'b0)) dut_m (
        .clkdiv4 (clk),
        .rxrst_n (rxrst_n),
        .gb      (ifm.slave)
    );

    int total = 0;
    int bad   = 0;

    logic       bits[$];
    logic [9:0] fill_word;

    task automatic push_word(input logic [9:0] w);
        for (int i = 0; i < 10; i++) bits.push_back(w[i]);
    endtask

    task automatic next_nibble(output logic [3:0] n);
        for (int i = 0; i < 4; i++) begin
            if (bits.size() == 0) push_word(fill_word);
            n[i] = bits.pop_front();
        end
    endtask

    // One clock: wait for the edge, let outputs settle, then drive next inputs.
    task automatic cyc(input logic bs);
        logic [3:0] n;
        @(posedge clk);
        #1;
        next_nibble(n);
        ifa.rxdata  = n;
        ifm.rxdata  = n;
        ifa.bitslip = bs;
        ifm.bitslip = bs;
    endtask

    // Reset, then start a stream of w preceded by `garbage` one-bits.
    task automatic do_reset(input int garbage, input logic [9:0] w);
        logic [3:0] n;
        rxrst_n = 1'b0;
        bits.delete();
        fill_word = w;
        for (int i = 0; i < garbage; i++) bits.push_back(1'b1);
        ifa.bitslip = 1'b0;
        ifm.bitslip = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        next_nibble(n);
        ifa.rxdata = n;
        ifm.rxdata = n;
        rxrst_n = 1'b1;
    endtask

    task automatic test_reset();
        rxrst_n = 1'b0;
        ifa.rxdata = 4'hF; ifm.rxdata = 4'hF;
        ifa.bitslip = 1'b0; ifm.bitslip = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (ifa.rxword !== 10'd0) begin bad++; $display("FAIL reset_rxword got=%h exp=000", ifa.rxword); end
        total++; if (ifa.rxword_vld !== 1'b0) begin bad++; $display("FAIL reset_vld got=%b exp=0", ifa.rxword_vld); end
        total++; if (ifa.aligned !== 1'b0) begin bad++; $display("FAIL reset_aligned got=%b exp=0", ifa.aligned); end
        total++; if (ifa.slip_cnt !== 4'd0) begin bad++; $display("FAIL reset_slip_cnt got=%0d exp=0", ifa.slip_cnt); end
        total++;
        if ({ifm.rxword, ifm.rxword_vld, ifm.aligned, ifm.slip_cnt} !== 16'd0) begin
            bad++; $display("FAIL reset_manual got=%h exp=0000", {ifm.rxword, ifm.rxword_vld, ifm.aligned, ifm.slip_cnt});
        end
    endtask

    task automatic test_phase0_lock();
        int nv50 = 0, ntok = 0, first_vld = 0, tok16 = 0, align_c = 0, wrong = 0;
        do_reset(0, 10'h354);
        for (int c = 1; c <= 100; c++) begin
            cyc(1'b0);
            if (ifa.rxword_vld === 1'b1) begin
                if (c <= 50) nv50++;
                if (first_vld == 0) first_vld = c;
                if (ifa.rxword !== 10'h354) wrong++;
                ntok++;
                if (ntok == 16) tok16 = c;
            end
            if (ifa.aligned === 1'b1 && align_c == 0) align_c = c;
        end
        total++; if (first_vld !== 3) begin bad++; $display("FAIL first_vld_cycle got=%0d exp=3", first_vld); end
        total++; if (nv50 !== 20) begin bad++; $display("FAIL vld_rate got=%0d exp=20 in 50 cycles", nv50); end
        total++; if (wrong !== 0) begin bad++; $display("FAIL phase0_word got=%0d bad words exp=0", wrong); end
        total++; if (align_c !== 41 || tok16 !== 40) begin bad++; $display("FAIL lock_time got=%0d/%0d exp=41/40", align_c, tok16); end
        total++; if (ifa.slip_cnt !== 4'd0) begin bad++; $display("FAIL phase0_slip_cnt got=%0d exp=0", ifa.slip_cnt); end
    endtask

    task automatic test_garbage_align();
        int words = 0, nchg = 0, wrong = 0, seen = 0;
        logic [3:0] prev_sc = 4'd0;
        logic locked = 1'b0;
        do_reset(3, 10'h354);
        for (int c = 0; c < 2000 && !locked; c++) begin
            cyc(1'b0);
            if (ifa.slip_cnt !== prev_sc) begin
                total++;
                if (words !== ((nchg == 0) ? 64 : 68)) begin
                    bad++; $display("FAIL slip_interval got=%0d exp=%0d", words, (nchg == 0) ? 64 : 68);
                end
                nchg++; words = 0; prev_sc = ifa.slip_cnt;
            end
            if (ifa.rxword_vld === 1'b1) words++;
            if (ifa.aligned === 1'b1) locked = 1'b1;
        end
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL garbage_lock_timeout got=%b exp=1", locked); end
        total++; if (ifa.slip_cnt !== 4'd3) begin bad++; $display("FAIL garbage_slip_cnt got=%0d exp=3", ifa.slip_cnt); end
        for (int c = 0; c < 40; c++) begin
            cyc(1'b0);
            if (ifa.rxword_vld === 1'b1) begin
                seen++;
                if (ifa.rxword !== 10'h354) wrong++;
            end
        end
        total++; if (wrong !== 0 || seen !== 16) begin bad++; $display("FAIL garbage_words got=%0d bad of %0d exp=0 of 16", wrong, seen); end
    endtask

    task automatic test_loss();
        int run = 0;
        logic saw_tok = 1'b0, done = 1'b0;
        for (int i = 0; i < 4095; i++) push_word(10'h1FF);
        push_word(10'h0AB);
        fill_word = 10'h1FF;
        for (int c = 0; c < 25000 && !done; c++) begin
            cyc(1'b0);
            if (ifa.rxword_vld === 1'b1) begin
                if (ifa.rxword === 10'h1FF) begin
                    run++;
                end else begin
                    run = 0;
                    if (ifa.rxword === 10'h0AB) saw_tok = 1'b1;
                end
                if (run == 4095 && !saw_tok) begin
                    total++; if (ifa.aligned !== 1'b1) begin bad++; $display("FAIL loss_hold_4095 got=%b exp=1", ifa.aligned); end
                end
                if (run == 4096) begin
                    total++; if (ifa.aligned !== 1'b1) begin bad++; $display("FAIL loss_at_4096 got=%b exp=1", ifa.aligned); end
                    cyc(1'b0);
                    total++; if (ifa.aligned !== 1'b0) begin bad++; $display("FAIL loss_drop got=%b exp=0", ifa.aligned); end
                    total++; if (saw_tok !== 1'b1) begin bad++; $display("FAIL loss_token_seen got=%b exp=1", saw_tok); end
                    total++; if (ifa.slip_cnt !== 4'd3) begin bad++; $display("FAIL loss_no_slip got=%0d exp=3", ifa.slip_cnt); end
                    done = 1'b1;
                end
            end
        end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL loss_timeout got=%b exp=1", done); end
    endtask

    task automatic test_manual_slip();
        int seen = 0, wrong = 0;
        logic ever_aligned = 1'b0;
        do_reset(7, 10'h2AB);
        ifa.bitslip = 1'b1;
        ifm.bitslip = 1'b1;   // first slip lands on a fill==0 cycle
        cyc(1'b0);
        total++; if (ifm.slip_cnt !== 4'd1) begin bad++; $display("FAIL manual_first_slip got=%0d exp=1", ifm.slip_cnt); end
        for (int k = 0; k < 6; k++) begin
            cyc(1'b1);
            cyc(1'b0);
        end
        for (int c = 0; c < 50; c++) begin
            cyc(1'b0);
            if (ifm.aligned === 1'b1) ever_aligned = 1'b1;
            if (c >= 10 && ifm.rxword_vld === 1'b1) begin
                seen++;
                if (ifm.rxword !== 10'h2AB) wrong++;
            end
        end
        total++; if (wrong !== 0 || seen !== 16) begin bad++; $display("FAIL manual_words got=%0d bad of %0d exp=0 of 16", wrong, seen); end
        total++; if (ifm.slip_cnt !== 4'd7) begin bad++; $display("FAIL manual_slip_cnt got=%0d exp=7", ifm.slip_cnt); end
        total++; if (ever_aligned !== 1'b0) begin bad++; $display("FAIL manual_aligned got=%b exp=0", ever_aligned); end
    endtask

    task automatic test_no_lock();
        int words = 0, nchg = 0, wraps = 0;
        logic [3:0] prev_sc = 4'd0;
        logic ever_aligned = 1'b0;
        do_reset(0, 10'h354);
        for (int g = 0; g < 300; g++) begin
            for (int i = 0; i < 9; i++) push_word(10'h354);
            push_word(10'h1FF);
        end
        for (int c = 0; c < 2200; c++) begin
            cyc(1'b0);
            if (ifa.aligned === 1'b1) ever_aligned = 1'b1;
            if (ifa.slip_cnt !== prev_sc) begin
                total++;
                if (words !== ((nchg == 0) ? 64 : 68) ||
                    ifa.slip_cnt !== ((prev_sc == 4'd9) ? 4'd0 : prev_sc + 4'd1)) begin
                    bad++; $display("FAIL nolock_slip got=%0d words cnt=%0d exp=%0d words cnt after %0d",
                                    words, ifa.slip_cnt, (nchg == 0) ? 64 : 68, prev_sc);
                end
                if (prev_sc == 4'd9) wraps++;
                nchg++; words = 0; prev_sc = ifa.slip_cnt;
            end
            if (ifa.rxword_vld === 1'b1) words++;
        end
        total++; if (ever_aligned !== 1'b0) begin bad++; $display("FAIL nolock_aligned got=%b exp=0", ever_aligned); end
        total++; if (nchg < 10 || wraps < 1) begin bad++; $display("FAIL nolock_wrap got=%0d slips %0d wraps exp>=10/>=1", nchg, wraps); end
    endtask

    task automatic test_reset_mid();
        logic locked = 1'b0;
        do_reset(2, 10'h354);
        for (int c = 0; c < 1500 && !locked; c++) begin
            cyc(1'b0);
            if (ifa.aligned === 1'b1) locked = 1'b1;
        end
        total++; if (locked !== 1'b1 || ifa.slip_cnt !== 4'd2) begin bad++; $display("FAIL mid_prelock got=%b/%0d exp=1/2", locked, ifa.slip_cnt); end
        @(posedge clk);
        #3;
        rxrst_n = 1'b0;
        #1;
        total++;
        if ({ifa.rxword, ifa.rxword_vld, ifa.aligned, ifa.slip_cnt} !== 16'd0) begin
            bad++; $display("FAIL mid_async_reset got=%h exp=0000", {ifa.rxword, ifa.rxword_vld, ifa.aligned, ifa.slip_cnt});
        end
        do_reset(0, 10'h354);
        locked = 1'b0;
        for (int c = 0; c < 200 && !locked; c++) begin
            cyc(1'b0);
            if (ifa.aligned === 1'b1) locked = 1'b1;
        end
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL mid_relock got=%b exp=1", locked); end
        total++; if (ifa.slip_cnt !== 4'd0 || ifa.rxword !== 10'h354) begin
            bad++; $display("FAIL mid_relock_state got=%0d/%h exp=0/354", ifa.slip_cnt, ifa.rxword);
        end
    endtask

    initial begin
        rxrst_n   = 1'b0;
        fill_word = 10'h354;
        test_reset();
        test_phase0_lock();
        test_garbage_align();
        test_loss();
        test_manual_slip();
        test_no_lock();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
